input_conditioner: RTL

- Producer side of the gamelogic control interface.
- Converts raw active-low DE1 pushbuttons into clean single-cycle command pulses: left_final, right_final, rot_final.
- Generates the tick_gravity pulse that paces piece descent.
- Sits between the board KEY pins and gamelogic. Every output is registered and glitch-free.

---
 rtl/input_conditioner.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Pushbutton front end for gamelogic: synchronise, debounce and pulse-shape the
// four DE1 keys, auto-repeat left/right, and pace piece descent with a gravity tick.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int GRAVITY_PERIOD  = 25000000,
  parameter int FAST_PERIOD     = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_left_n,
  input  logic       key_right_n,
  input  logic       key_rot_n,
  input  logic       key_drop_n,
  input  logic       pause,
  output logic       left_final,
  output logic       right_final,
  output logic       rot_final,
  output logic       tick_gravity,
  output logic       drop_held,
  output logic [1:0] left_state_o,
  output logic [1:0] right_state_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES - 1) + 1;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY - 1 : REPEAT_RATE - 1;
  localparam int RP_W   = $clog2(RP_MAX) + 1;
  localparam int GR_MAX = (GRAVITY_PERIOD > FAST_PERIOD) ? GRAVITY_PERIOD - 1 : FAST_PERIOD - 1;
  localparam int GR_W   = $clog2(GR_MAX) + 1;

  localparam logic [DB_W-1:0] DB_TERM   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RD_TERM   = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RR_TERM   = RP_W'(REPEAT_RATE - 1);
  localparam logic [GR_W-1:0] GRAV_TERM = GR_W'(GRAVITY_PERIOD - 1);
  localparam logic [GR_W-1:0] FAST_TERM = GR_W'(FAST_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  // Key index: 0 left, 1 right, 2 rotate, 3 soft-drop (1 = pressed).
  logic [3:0]      raw_pressed;
  logic [3:0]      sync1_q, sync2_q, deb_q;
  logic [2:0]      deb_dly_q;
  logic [DB_W-1:0] db_cnt_q [4];
  logic [2:0]      rise;

  assign raw_pressed = ~{key_drop_n, key_rot_n, key_right_n, key_left_n};
  assign rise        = deb_q[2:0] & ~deb_dly_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int k = 0; k < 4; k++) db_cnt_q[k] <= '0;
    end else begin
      sync1_q   <= raw_pressed;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q[2:0];
      for (int k = 0; k < 4; k++) begin
        if (sync2_q[k] == deb_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DB_TERM) begin
          deb_q[k]    <= ~deb_q[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  rpt_state_e      rpt_st_q  [2];
  logic [RP_W-1:0] rpt_cnt_q [2];
  logic [1:0]      want;
  logic            left_q, right_q, rot_q;

  // A key "wants" a pulse on its press edge or when its repeat counter hits terminal.
  always_comb begin
    want = '0;
    for (int k = 0; k < 2; k++) begin
      if (deb_q[k]) begin
        case (rpt_st_q[k])
          ST_IDLE:   want[k] = rise[k];
          ST_DELAY:  want[k] = !pause && (rpt_cnt_q[k] == RD_TERM);
          ST_REPEAT: want[k] = !pause && (rpt_cnt_q[k] == RR_TERM);
          default:   want[k] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      rot_q   <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        rpt_st_q[k]  <= ST_IDLE;
        rpt_cnt_q[k] <= '0;
      end
    end else begin
      // Simultaneous left and right cancel each other; counters keep running.
      left_q  <= want[0] & ~want[1];
      right_q <= want[1] & ~want[0];
      rot_q   <= rise[2];
      for (int k = 0; k < 2; k++) begin
        if (!deb_q[k]) begin
          rpt_st_q[k]  <= ST_IDLE;
          rpt_cnt_q[k] <= '0;
        end else begin
          case (rpt_st_q[k])
            ST_IDLE: begin
              if (rise[k]) begin
                rpt_st_q[k]  <= ST_DELAY;
                rpt_cnt_q[k] <= '0;
              end
            end
            ST_DELAY: begin
              if (!pause) begin
                if (rpt_cnt_q[k] == RD_TERM) begin
                  rpt_st_q[k]  <= ST_REPEAT;
                  rpt_cnt_q[k] <= '0;
                end else begin
                  rpt_cnt_q[k] <= rpt_cnt_q[k] + RP_W'(1);
                end
              end
            end
            ST_REPEAT: begin
              if (!pause) begin
                if (rpt_cnt_q[k] == RR_TERM) rpt_cnt_q[k] <= '0;
                else rpt_cnt_q[k] <= rpt_cnt_q[k] + RP_W'(1);
              end
            end
            default: rpt_st_q[k] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  logic [GR_W-1:0] grav_cnt_q, grav_term;
  logic            tick_q, drop_held_q;

  // ">=" lets a soft-drop that starts late in a slow period tick right away.
  assign grav_term = drop_held_q ? FAST_TERM : GRAV_TERM;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      grav_cnt_q  <= '0;
      tick_q      <= 1'b0;
      drop_held_q <= 1'b0;
    end else begin
      drop_held_q <= deb_q[3];
      tick_q      <= 1'b0;
      if (!pause) begin
        if (grav_cnt_q >= grav_term) begin
          tick_q     <= 1'b1;
          grav_cnt_q <= '0;
        end else begin
          grav_cnt_q <= grav_cnt_q + GR_W'(1);
        end
      end
    end
  end

  assign left_final    = left_q;
  assign right_final   = right_q;
  assign rot_final     = rot_q;
  assign tick_gravity  = tick_q;
  assign drop_held     = drop_held_q;
  assign left_state_o  = rpt_st_q[0];
  assign right_state_o = rpt_st_q[1];

endmodule
